// File: rtl/arm_cond_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : arm_cond_unit
// Purpose  : ARM condition evaluation, NZCV flag storage and write gating
// Revision : 1.0
// ============================================================================
module arm_cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  localparam logic [3:0] C_EQ  = 4'b0000;
  localparam logic [3:0] C_NE  = 4'b0001;
  localparam logic [3:0] C_CS  = 4'b0010;
  localparam logic [3:0] C_CC  = 4'b0011;
  localparam logic [3:0] C_MI  = 4'b0100;
  localparam logic [3:0] C_PL  = 4'b0101;
  localparam logic [3:0] C_VS  = 4'b0110;
  localparam logic [3:0] C_VC  = 4'b0111;
  localparam logic [3:0] C_HI  = 4'b1000;
  localparam logic [3:0] C_LS  = 4'b1001;
  localparam logic [3:0] C_GE  = 4'b1010;
  localparam logic [3:0] C_LT  = 4'b1011;
  localparam logic [3:0] C_GT  = 4'b1100;
  localparam logic [3:0] C_LE  = 4'b1101;
  localparam logic [3:0] C_AL  = 4'b1110;

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       w_n, w_z, w_c, w_v;
  logic       w_cond_ex;
  logic [1:0] w_flag_write;

  assign Flags = {nz_q, cv_q};
  assign w_n   = nz_q[1];
  assign w_z   = nz_q[0];
  assign w_c   = cv_q[1];
  assign w_v   = cv_q[0];

  // Evaluated on stored flags only; the current instruction never sees its own ALU flags.
  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      C_EQ:    w_cond_ex = w_z;
      C_NE:    w_cond_ex = ~w_z;
      C_CS:    w_cond_ex = w_c;
      C_CC:    w_cond_ex = ~w_c;
      C_MI:    w_cond_ex = w_n;
      C_PL:    w_cond_ex = ~w_n;
      C_VS:    w_cond_ex = w_v;
      C_VC:    w_cond_ex = ~w_v;
      C_HI:    w_cond_ex = w_c & ~w_z;
      C_LS:    w_cond_ex = ~w_c | w_z;
      C_GE:    w_cond_ex = ~(w_n ^ w_v);
      C_LT:    w_cond_ex = w_n ^ w_v;
      C_GT:    w_cond_ex = ~w_z & ~(w_n ^ w_v);
      C_LE:    w_cond_ex = w_z | (w_n ^ w_v);
      C_AL:    w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    w_flag_write = FlagW & {2{w_cond_ex}};
    RegWrite     = RegW & w_cond_ex;
    MemWrite     = MemW & w_cond_ex;
    PCSrc        = PCS  & w_cond_ex;
  end

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (w_flag_write[1]) nz_d = ALUFlags[3:2];
    if (w_flag_write[0]) cv_d = ALUFlags[1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arm_cond_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_arm_cond_unit
// Purpose  : Directed vector bench for arm_cond_unit
// Revision : 1.0
// ============================================================================
module tb_arm_cond_unit;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;
  logic       PCSrc, RegWrite, MemWrite;
  logic [3:0] Flags;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  arm_cond_unit dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    reset = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;
    tick();
  endtask

  function automatic vec_t mk(input logic [3:0] f, input logic [3:0] c, input logic e);
    vec_t v;
    v.flags = f; v.cond = c; v.exp = e;
    return v;
  endfunction

  initial begin
    // Flags 0000: every code
    vecs.push_back(mk(4'b0000, 4'h0, 0)); vecs.push_back(mk(4'b0000, 4'h1, 1));
    vecs.push_back(mk(4'b0000, 4'h2, 0)); vecs.push_back(mk(4'b0000, 4'h3, 1));
    vecs.push_back(mk(4'b0000, 4'h4, 0)); vecs.push_back(mk(4'b0000, 4'h5, 1));
    vecs.push_back(mk(4'b0000, 4'h6, 0)); vecs.push_back(mk(4'b0000, 4'h7, 1));
    vecs.push_back(mk(4'b0000, 4'h8, 0)); vecs.push_back(mk(4'b0000, 4'h9, 1));
    vecs.push_back(mk(4'b0000, 4'hA, 1)); vecs.push_back(mk(4'b0000, 4'hB, 0));
    vecs.push_back(mk(4'b0000, 4'hC, 1)); vecs.push_back(mk(4'b0000, 4'hD, 0));
    vecs.push_back(mk(4'b0000, 4'hE, 1)); vecs.push_back(mk(4'b0000, 4'hF, 0));
    // Flags 1111: every code
    vecs.push_back(mk(4'b1111, 4'h0, 1)); vecs.push_back(mk(4'b1111, 4'h1, 0));
    vecs.push_back(mk(4'b1111, 4'h2, 1)); vecs.push_back(mk(4'b1111, 4'h3, 0));
    vecs.push_back(mk(4'b1111, 4'h4, 1)); vecs.push_back(mk(4'b1111, 4'h5, 0));
    vecs.push_back(mk(4'b1111, 4'h6, 1)); vecs.push_back(mk(4'b1111, 4'h7, 0));
    vecs.push_back(mk(4'b1111, 4'h8, 0)); vecs.push_back(mk(4'b1111, 4'h9, 1));
    vecs.push_back(mk(4'b1111, 4'hA, 1)); vecs.push_back(mk(4'b1111, 4'hB, 0));
    vecs.push_back(mk(4'b1111, 4'hC, 0)); vecs.push_back(mk(4'b1111, 4'hD, 1));
    vecs.push_back(mk(4'b1111, 4'hE, 1)); vecs.push_back(mk(4'b1111, 4'hF, 0));
    // N=1,V=1
    vecs.push_back(mk(4'b1001, 4'hA, 1)); vecs.push_back(mk(4'b1001, 4'hB, 0));
    vecs.push_back(mk(4'b1001, 4'hC, 1)); vecs.push_back(mk(4'b1001, 4'hD, 0));
    vecs.push_back(mk(4'b1001, 4'h8, 0)); vecs.push_back(mk(4'b1001, 4'h9, 1));
    // C=1 only
    vecs.push_back(mk(4'b0010, 4'h8, 1)); vecs.push_back(mk(4'b0010, 4'h9, 0));
    vecs.push_back(mk(4'b0010, 4'h2, 1)); vecs.push_back(mk(4'b0010, 4'h3, 0));
    // N=1 only
    vecs.push_back(mk(4'b1000, 4'hA, 0)); vecs.push_back(mk(4'b1000, 4'hB, 1));
    vecs.push_back(mk(4'b1000, 4'hC, 0)); vecs.push_back(mk(4'b1000, 4'hD, 1));
    vecs.push_back(mk(4'b1000, 4'h4, 1)); vecs.push_back(mk(4'b1000, 4'h5, 0));
    // V=1 only
    vecs.push_back(mk(4'b0001, 4'hA, 0)); vecs.push_back(mk(4'b0001, 4'hB, 1));
    vecs.push_back(mk(4'b0001, 4'h6, 1)); vecs.push_back(mk(4'b0001, 4'h7, 0));
    vecs.push_back(mk(4'b0001, 4'hC, 0)); vecs.push_back(mk(4'b0001, 4'hD, 1));
    // Z=1,C=1
    vecs.push_back(mk(4'b0110, 4'h8, 0)); vecs.push_back(mk(4'b0110, 4'h9, 1));
    vecs.push_back(mk(4'b0110, 4'h0, 1)); vecs.push_back(mk(4'b0110, 4'hC, 0));
    vecs.push_back(mk(4'b0110, 4'hD, 1)); vecs.push_back(mk(4'b0110, 4'h1, 0));

    // Reset with a pending flag write
    reset = 1'b0; Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b11;
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
    tick(); tick();
    check("reset_flags", Flags, 4'b0000);
    check("reset_regwrite", {3'b0, RegWrite}, 4'd1);
    check("reset_memwrite", {3'b0, MemWrite}, 4'd1);
    check("reset_pcsrc", {3'b0, PCSrc}, 4'd1);

    // Condition table
    for (int i = 0; i < vecs.size(); i++) begin
      load_flags(vecs[i].flags);
      check($sformatf("load_%b", vecs[i].flags), Flags, vecs[i].flags);
      Cond = vecs[i].cond; FlagW = 2'b00; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
      #1;
      check($sformatf("regw_f%b_c%h", vecs[i].flags, vecs[i].cond), {3'b0, RegWrite}, {3'b0, vecs[i].exp});
      check($sformatf("memw_f%b_c%h", vecs[i].flags, vecs[i].cond), {3'b0, MemWrite}, {3'b0, vecs[i].exp});
      check($sformatf("pcs_f%b_c%h", vecs[i].flags, vecs[i].cond), {3'b0, PCSrc}, {3'b0, vecs[i].exp});
      RegW = 1'b0;
      #1;
      check($sformatf("regw0_f%b_c%h", vecs[i].flags, vecs[i].cond), {3'b0, RegWrite}, 4'd0);
    end

    // Independent flag groups
    load_flags(4'b0000);
    ALUFlags = 4'b1111; FlagW = 2'b10; Cond = 4'b1110;
    tick();
    check("group_nz", Flags, 4'b1100);
    FlagW = 2'b01; ALUFlags = 4'b0000;
    tick();
    check("group_cv0", Flags, 4'b1100);
    FlagW = 2'b01; ALUFlags = 4'b0011;
    tick();
    check("group_cv1", Flags, 4'b1111);

    // Failing condition blocks all writes
    load_flags(4'b0000);
    Cond = 4'b0000; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
    #1;
    check("gate_regwrite", {3'b0, RegWrite}, 4'd0);
    check("gate_memwrite", {3'b0, MemWrite}, 4'd0);
    check("gate_pcsrc", {3'b0, PCSrc}, 4'd0);
    tick();
    check("gate_flags", Flags, 4'b0000);

    // Reserved code never writes flags
    load_flags(4'b0101);
    Cond = 4'b1111; FlagW = 2'b11; ALUFlags = 4'b1010;
    tick();
    check("rsv_flags", Flags, 4'b0101);

    // No same-cycle forwarding
    load_flags(4'b0000);
    Cond = 4'b0000; ALUFlags = 4'b0100; FlagW = 2'b11; RegW = 1'b1;
    #1;
    check("fwd_condex", {3'b0, RegWrite}, 4'd0);
    tick();
    check("fwd_flags", Flags, 4'b0000);
    Cond = 4'b1110;
    tick();
    check("fwd_loadz", Flags, 4'b0100);
    Cond = 4'b0000; FlagW = 2'b00;
    #1;
    check("fwd_eq_next", {3'b0, RegWrite}, 4'd1);

    // Mid-run reset discards the concurrent flag write
    load_flags(4'b1111);
    reset = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1010; Cond = 4'b1110;
    tick();
    check("midrst_flags", Flags, 4'b0000);
    reset = 1'b1; FlagW = 2'b00; Cond = 4'b0001; RegW = 1'b1;
    #1;
    check("midrst_ne1", {3'b0, RegWrite}, 4'd1);
    RegW = 1'b0;
    #1;
    check("midrst_ne0", {3'b0, RegWrite}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
